// File: rtl/axi_rd_burst_engine_if.sv
// Bundle of command, FIFO-write, AXI4 read-address/read-data and status signals
// shared between the burst engine (master) and its environment (slave).
interface axi_rd_burst_engine_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic [DATA_W-1:0] arg_0_in_data;
    logic              arg_0_write_valid;
    logic              arg_0_write_ready;

    logic [ADDR_W-1:0] s_axi_araddr;
    logic [1:0]        s_axi_arburst;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    logic              done;
    logic [1:0]        err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, arg_0_write_ready,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output cmd_ready, arg_0_in_data, arg_0_write_valid,
               s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arsize, s_axi_arvalid,
               s_axi_rready, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, arg_0_write_ready,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  cmd_ready, arg_0_in_data, arg_0_write_valid,
               s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arsize, s_axi_arvalid,
               s_axi_rready, done, err
    );
endinterface

// File: rtl/axi_rd_burst_engine.sv
// AXI4 read-burst master: splits a (start address, beat count) command into INCR bursts of
// at most MAX_BURST beats and streams the returned beats into a FIFO write port.
module axi_rd_burst_engine #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    axi_rd_burst_engine_if.master bus
);
    localparam int unsigned BytesPerBeat = DATA_W / 8;
    localparam int unsigned BeatShift    = $clog2(BytesPerBeat);
    localparam logic [2:0]  ArSize       = 3'(BeatShift);
    localparam int unsigned CmpW         = (LEN_W > 9) ? LEN_W : 9;

    typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

    state_e            r_state;
    logic              r_cmd_ready;
    logic              r_arvalid;
    logic [7:0]        r_arlen;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [8:0]        r_burst_beats;
    logic [8:0]        r_beat_cnt;
    logic              r_done;
    logic [1:0]        r_err;

    logic              w_in_r;
    logic              w_beat;
    logic              w_final;
    logic [LEN_W-1:0]  w_rem_dec;
    logic [ADDR_W-1:0] w_addr_inc;

    function automatic logic [8:0] burst_len(input logic [LEN_W-1:0] rem);
        if (CmpW'(rem) > CmpW'(MAX_BURST)) begin
            return 9'(MAX_BURST);
        end
        return 9'(rem);
    endfunction

    assign w_in_r     = (r_state == StR);
    assign w_beat     = w_in_r && bus.s_axi_rvalid && bus.arg_0_write_ready;
    assign w_final    = (r_beat_cnt == r_burst_beats - 9'd1);
    assign w_rem_dec  = r_remaining - LEN_W'(1);
    assign w_addr_inc = ADDR_W'(r_burst_beats) << BeatShift;

    // R-channel path is a zero-latency pass-through gated by FIFO space.
    assign bus.s_axi_rready      = w_in_r && bus.arg_0_write_ready;
    assign bus.arg_0_write_valid = w_beat;
    assign bus.arg_0_in_data     = w_in_r ? bus.s_axi_rdata : '0;

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.s_axi_araddr  = r_cur_addr;
    assign bus.s_axi_arburst = 2'b01;
    assign bus.s_axi_arlen   = r_arlen;
    assign bus.s_axi_arsize  = ArSize;
    assign bus.s_axi_arvalid = r_arvalid;
    assign bus.done          = r_done;
    assign bus.err           = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cmd_ready   <= 1'b0;
            r_arvalid     <= 1'b0;
            r_arlen       <= '0;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_burst_beats <= '0;
            r_beat_cnt    <= '0;
            r_done        <= 1'b0;
            r_err         <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_err       <= '0;
                        r_cur_addr  <= bus.cmd_addr;
                        r_remaining <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= StAr;
                            r_arvalid <= 1'b1;
                            r_arlen   <= 8'(burst_len(bus.cmd_len) - 9'd1);
                        end
                    end
                end
                StAr: begin
                    if (bus.s_axi_arready) begin
                        r_arvalid     <= 1'b0;
                        r_burst_beats <= 9'(r_arlen) + 9'd1;
                        r_beat_cnt    <= '0;
                        r_state       <= StR;
                    end
                end
                StR: begin
                    if (w_beat) begin
                        r_beat_cnt  <= r_beat_cnt + 9'd1;
                        r_remaining <= w_rem_dec;
                        if (bus.s_axi_rresp != 2'b00) begin
                            r_err[0] <= 1'b1;
                        end
                        if (bus.s_axi_rlast != w_final) begin
                            r_err[1] <= 1'b1;
                        end
                        // Burst length comes from our own count; rlast is only checked.
                        if (w_final) begin
                            r_cur_addr <= r_cur_addr + w_addr_inc;
                            if (w_rem_dec != '0) begin
                                r_state   <= StAr;
                                r_arvalid <= 1'b1;
                                r_arlen   <= 8'(burst_len(w_rem_dec) - 9'd1);
                            end else begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    r_state     <= StIdle;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_burst_engine.sv
// Directed self-checking bench for axi_rd_burst_engine: inputs change 1 ns after the rising
// edge, outputs are checked a further 1 ns later or right after an edge has settled.
module tb_axi_rd_burst_engine;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MAX_BURST = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] t2_addr [3] = '{16'h0000, 16'h0040, 16'h0080};
    logic [7:0]  t2_len  [3] = '{8'd15, 8'd15, 8'd7};
    logic [15:0] t7_addr [2] = '{16'hffc0, 16'h0000};

    always #5 clk = ~clk;

    axi_rd_burst_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    axi_rd_burst_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input string tag, input logic [15:0] a, input logic [15:0] l);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, " cmd_ready before"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        step();
        bus.cmd_valid = 1'b0;
        check({tag, " cmd_ready after"}, 64'(bus.cmd_ready), 64'd0);
    endtask

    task automatic expect_ar(input string tag, input logic [15:0] a, input logic [7:0] l);
        int n = 0;
        while (bus.s_axi_arvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, " arvalid"}, 64'(bus.s_axi_arvalid), 64'd1);
        check({tag, " araddr"}, 64'(bus.s_axi_araddr), 64'(a));
        check({tag, " arlen"}, 64'(bus.s_axi_arlen), 64'(l));
        check({tag, " arsize"}, 64'(bus.s_axi_arsize), 64'd2);
        check({tag, " arburst"}, 64'(bus.s_axi_arburst), 64'd1);
        bus.s_axi_arready = 1'b1;
        step();
        bus.s_axi_arready = 1'b0;
        check({tag, " arvalid drop"}, 64'(bus.s_axi_arvalid), 64'd0);
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
        bus.s_axi_rvalid      = 1'b1;
        bus.s_axi_rdata       = d;
        bus.s_axi_rresp       = resp;
        bus.s_axi_rlast       = last;
        bus.arg_0_write_ready = 1'b1;
        #1;
        check({tag, " rready"}, 64'(bus.s_axi_rready), 64'd1);
        check({tag, " write_valid"}, 64'(bus.arg_0_write_valid), 64'd1);
        check({tag, " in_data"}, 64'(bus.arg_0_in_data), 64'(d));
        step();
        bus.s_axi_rvalid = 1'b0;
        bus.s_axi_rresp  = 2'b00;
        bus.s_axi_rlast  = 1'b0;
    endtask

    initial begin
        bus.cmd_valid         = 1'b0;
        bus.cmd_addr          = '0;
        bus.cmd_len           = '0;
        bus.arg_0_write_ready = 1'b1;
        bus.s_axi_arready     = 1'b0;
        bus.s_axi_rdata       = 32'hdead_beef;
        bus.s_axi_rresp       = 2'b00;
        bus.s_axi_rlast       = 1'b0;
        bus.s_axi_rvalid      = 1'b0;

        // Reset values
        step();
        step();
        check("rst cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst arvalid", 64'(bus.s_axi_arvalid), 64'd0);
        check("rst araddr", 64'(bus.s_axi_araddr), 64'd0);
        check("rst arlen", 64'(bus.s_axi_arlen), 64'd0);
        check("rst arburst", 64'(bus.s_axi_arburst), 64'd1);
        check("rst arsize", 64'(bus.s_axi_arsize), 64'd2);
        check("rst rready", 64'(bus.s_axi_rready), 64'd0);
        check("rst write_valid", 64'(bus.arg_0_write_valid), 64'd0);
        check("rst in_data", 64'(bus.arg_0_in_data), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst err", 64'(bus.err), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel cmd_ready low", 64'(bus.cmd_ready), 64'd0);
        step();
        check("rel cmd_ready high", 64'(bus.cmd_ready), 64'd1);

        // T1: single 4-beat burst at 0x100, arready delayed one cycle
        send_cmd("t1", 16'h0100, 16'd4);
        check("t1 araddr held", 64'(bus.s_axi_araddr), 64'h100);
        step();
        check("t1 araddr stable", 64'(bus.s_axi_araddr), 64'h100);
        check("t1 arlen stable", 64'(bus.s_axi_arlen), 64'd3);
        expect_ar("t1 ar", 16'h0100, 8'd3);
        for (int i = 0; i < 4; i++) begin
            check("t1 done early", 64'(bus.done), 64'd0);
            beat("t1 beat", 32'ha0 + 32'(i), 2'b00, i == 3);
        end
        check("t1 done", 64'(bus.done), 64'd1);
        check("t1 err", 64'(bus.err), 64'd0);
        step();
        check("t1 done one cycle", 64'(bus.done), 64'd0);
        check("t1 idle cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // T2: 40 beats from 0x0 split 16/16/8
        send_cmd("t2", 16'h0000, 16'd40);
        for (int b = 0; b < 3; b++) begin
            expect_ar("t2 ar", t2_addr[b], t2_len[b]);
            for (int i = 0; i <= int'(t2_len[b]); i++) begin
                beat("t2 beat", 32'(b * 16 + i), 2'b00, i == int'(t2_len[b]));
                if (b != 2 || i != int'(t2_len[b])) begin
                    check("t2 no early done", 64'(bus.done), 64'd0);
                end
            end
        end
        check("t2 done", 64'(bus.done), 64'd1);
        check("t2 err", 64'(bus.err), 64'd0);
        step();
        check("t2 done one cycle", 64'(bus.done), 64'd0);

        // T3: write_ready 1,0,0,1 with rvalid held high
        send_cmd("t3", 16'h0200, 16'd2);
        expect_ar("t3 ar", 16'h0200, 8'd1);
        bus.s_axi_rvalid      = 1'b1;
        bus.s_axi_rdata       = 32'h1111;
        bus.arg_0_write_ready = 1'b1;
        #1;
        check("t3 c0 rready", 64'(bus.s_axi_rready), 64'd1);
        check("t3 c0 write_valid", 64'(bus.arg_0_write_valid), 64'd1);
        check("t3 c0 in_data", 64'(bus.arg_0_in_data), 64'h1111);
        step();
        bus.s_axi_rdata       = 32'h2222;
        bus.arg_0_write_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3 stall rready", 64'(bus.s_axi_rready), 64'd0);
            check("t3 stall write_valid", 64'(bus.arg_0_write_valid), 64'd0);
            step();
            check("t3 stall done", 64'(bus.done), 64'd0);
        end
        bus.arg_0_write_ready = 1'b1;
        bus.s_axi_rlast       = 1'b1;
        #1;
        check("t3 c3 rready", 64'(bus.s_axi_rready), 64'd1);
        check("t3 c3 write_valid", 64'(bus.arg_0_write_valid), 64'd1);
        check("t3 c3 in_data", 64'(bus.arg_0_in_data), 64'h2222);
        step();
        bus.s_axi_rvalid = 1'b0;
        bus.s_axi_rlast  = 1'b0;
        check("t3 done", 64'(bus.done), 64'd1);
        check("t3 err", 64'(bus.err), 64'd0);
        step();

        // T4: SLVERR on beat 2 and missing rlast on beat 3
        send_cmd("t4", 16'h0400, 16'd3);
        expect_ar("t4 ar", 16'h0400, 8'd2);
        beat("t4 beat0", 32'hb0, 2'b00, 1'b0);
        beat("t4 beat1", 32'hb1, 2'b10, 1'b0);
        check("t4 err after resp", 64'(bus.err), 64'd1);
        beat("t4 beat2", 32'hb2, 2'b00, 1'b0);
        check("t4 done", 64'(bus.done), 64'd1);
        check("t4 err at done", 64'(bus.err), 64'd3);
        step();
        check("t4 err sticky idle", 64'(bus.err), 64'd3);

        // T5: zero-length command clears err and completes without AR
        send_cmd("t5", 16'h0500, 16'd0);
        check("t5 err cleared", 64'(bus.err), 64'd0);
        check("t5 no ar", 64'(bus.s_axi_arvalid), 64'd0);
        check("t5 done", 64'(bus.done), 64'd1);
        step();
        check("t5 done one cycle", 64'(bus.done), 64'd0);
        check("t5 no ar later", 64'(bus.s_axi_arvalid), 64'd0);
        check("t5 cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // T6: reset after 2 of 8 beats, then a fresh command
        send_cmd("t6", 16'h0300, 16'd8);
        expect_ar("t6 ar", 16'h0300, 8'd7);
        beat("t6 beat0", 32'hc0, 2'b00, 1'b0);
        beat("t6 beat1", 32'hc1, 2'b00, 1'b0);
        bus.s_axi_rvalid = 1'b1;
        bus.s_axi_rdata  = 32'hc2;
        rst_n = 1'b0;
        #1;
        check("t6 rst rready", 64'(bus.s_axi_rready), 64'd0);
        check("t6 rst write_valid", 64'(bus.arg_0_write_valid), 64'd0);
        check("t6 rst in_data", 64'(bus.arg_0_in_data), 64'd0);
        check("t6 rst arvalid", 64'(bus.s_axi_arvalid), 64'd0);
        check("t6 rst araddr", 64'(bus.s_axi_araddr), 64'd0);
        check("t6 rst cmd_ready", 64'(bus.cmd_ready), 64'd0);
        step();
        bus.s_axi_rvalid = 1'b0;
        check("t6 rst held arvalid", 64'(bus.s_axi_arvalid), 64'd0);
        rst_n = 1'b1;
        step();
        check("t6 rel cmd_ready", 64'(bus.cmd_ready), 64'd1);
        send_cmd("t6b", 16'h0010, 16'd1);
        expect_ar("t6b ar", 16'h0010, 8'd0);
        beat("t6b beat", 32'hd0, 2'b00, 1'b1);
        check("t6b done", 64'(bus.done), 64'd1);
        check("t6b err", 64'(bus.err), 64'd0);
        step();

        // T7: address wraps past the top of the 16-bit space
        send_cmd("t7", 16'hffc0, 16'd32);
        for (int b = 0; b < 2; b++) begin
            expect_ar("t7 ar", t7_addr[b], 8'd15);
            for (int i = 0; i < 16; i++) begin
                beat("t7 beat", 32'he00 + 32'(b * 16 + i), 2'b00, i == 15);
            end
        end
        check("t7 done", 64'(bus.done), 64'd1);
        check("t7 err", 64'(bus.err), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
